// File: rtl/uart_tx_arbiter_if.sv
// Requester bus plus the uart_tx launch/busy handshake shared by the arbiter.
// master: the environment (byte producers and uart_tx); slave: the arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_p_data;
    logic                 tx_data_valid;
    logic                 tx_busy;

    modport master (
        output req_valid, req_data, tx_busy,
        input  req_ready, tx_p_data, tx_data_valid
    );

    modport slave (
        input  req_valid, req_data, tx_busy,
        output req_ready, tx_p_data, tx_data_valid
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers.
// Accepts one byte, pulses DATA_VALID once, then tracks Busy for the whole
// frame so launches never overlap. Optional macro UART_ARB_STATS_EN adds a
// 16-bit frames_sent counter of completed frames.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_tx_arbiter_if.slave    bus,
    output logic [2:0]          grant_id,
    output logic                timeout_err
`ifdef UART_ARB_STATS_EN
    ,
    output logic [15:0]         frames_sent
`endif
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    localparam int         CW    = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [3:0] NREQ  = 4'(NUM_REQ);
    localparam logic [2:0] LAST  = 3'(NUM_REQ - 1);

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [2:0]           rr_ptr;
    logic [NUM_REQ-1:0]   rot;
    logic [2:0]           off, win;
    logic [3:0]           sum;
    logic                 found, grant, set_err;
    logic [7:0]           win_data;
    logic [NUM_REQ-1:0]   ready;
    logic                 dv;

    // Rotate valids so bit 0 is rr_ptr, take the first set bit, map back.
    always_comb begin
        rot   = NUM_REQ'({bus.req_valid, bus.req_valid} >> rr_ptr);
        found = 1'b0;
        off   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = 3'(i);
            end
        end
        sum = {1'b0, rr_ptr} + {1'b0, off};
        win = (sum >= NREQ) ? 3'(sum - NREQ) : sum[2:0];
    end

    // Byte of the winning requester, muxed with constant slices.
    always_comb begin
        win_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (3'(i) == win) win_data = bus.req_data[8*i +: 8];
        end
    end

    // Grants only happen from IDLE while uart_tx is free.
    assign grant = (state == IDLE) && !bus.tx_busy && found;

    // Next-state, timeout counter and handshake outputs.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ready     = '0;
        dv        = 1'b0;
        set_err   = 1'b0;
        case (state)
            IDLE: begin
                if (grant) begin
                    ready     = NUM_REQ'(1) << win;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                dv        = 1'b1;
                cnt_nxt   = CW'(BUSY_TIMEOUT);
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (cnt <= CW'(1)) begin
                    // Last decrement reaches zero: give up on this launch.
                    cnt_nxt   = '0;
                    set_err   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.req_ready     = ready;
    assign bus.tx_data_valid = dv;

    // State, counter, round-robin pointer and latched launch data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            rr_ptr        <= '0;
            bus.tx_p_data <= 8'h00;
            grant_id      <= '0;
            timeout_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (grant) begin
                bus.tx_p_data <= win_data;
                grant_id      <= win;
                rr_ptr        <= (win == LAST) ? 3'd0 : win + 3'd1;
            end
            if (set_err) timeout_err <= 1'b1;
        end
    end

`ifdef UART_ARB_STATS_EN
    // Count frames that ran to completion (WAIT_DONE -> IDLE).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_sent <= 16'h0000;
        end else if (state == WAIT_DONE && !bus.tx_busy) begin
            frames_sent <= frames_sent + 16'd1;
        end
    end
`endif
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin controller that shares a single `uart_tx` transmitter between `NUM_REQ` byte producers. It accepts one byte from the winning requester, launches it into `uart_tx` with a one-cycle `DATA_VALID` pulse, and then tracks `Busy` through the whole frame. It sits directly in front of `uart_tx`, so the UART datapath never sees two overlapping launches.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `BUSY_TIMEOUT`, default 15: maximum cycles to wait for `Busy` to rise after a launch.

Ports:
- `clk`  in  1  system clock; all logic rises on posedge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  NUM_REQ  per-requester byte available.
- `req_data`  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i].
- `req_ready`  out  NUM_REQ  one-hot acceptance strobe; a byte transfers when valid and ready are both high.
- `tx_p_data`  out  8  to `uart_tx` P_DATA.
- `tx_data_valid`  out  1  to `uart_tx` DATA_VALID; one-cycle pulse.
- `tx_busy`  in  1  from `uart_tx` Busy.
- `grant_id`  out  3  index of the requester owning the current frame.
- `timeout_err`  out  1  sticky; set when `Busy` never rose after a launch.

## Operation
States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.

- **IDLE**
  - If any `req_valid` is high and `tx_busy` is 0, pick winner w by round-robin.
  - Search starts at `rr_ptr` and wraps modulo NUM_REQ.
  - Drive `req_ready[w]`=1 combinationally in this cycle.
  - At the clock edge: latch `req_data[w]` into `tx_p_data`, set `grant_id`=w and `rr_ptr`=(w+1) mod NUM_REQ, then go to ISSUE.
  - If `tx_busy`=1 in IDLE, nothing is granted.
- **ISSUE**
  - `tx_data_valid`=1 for exactly this cycle.
  - Load the timeout counter with `BUSY_TIMEOUT`, then go to WAIT_BUSY.
- **WAIT_BUSY**
  - If `tx_busy`=1, go to WAIT_DONE.
  - Otherwise decrement the counter. When it reaches 0, set `timeout_err` and return to IDLE.
- **WAIT_DONE**
  - When `tx_busy`=0, return to IDLE.
- Outside IDLE, `req_ready` is all zeros.
- `tx_p_data` and `grant_id` hold stable from the latch edge until the next grant.
- Requesters whose `req_valid` is high but are not granted keep their data; there is no drop and no internal queue.
- If `req_valid[w]` falls in the same cycle as a grant, no grant occurs: the winner is computed from the current `req_valid` only.
- `timeout_err` clears only on reset.
- Reset asserted mid-frame: all state goes to reset values immediately. The in-flight `uart_tx` frame is not this block's concern.

Reset values:
- state IDLE, `rr_ptr`=0
- `req_ready`=0, `tx_data_valid`=0, `tx_p_data`=8'h00
- `grant_id`=0, `timeout_err`=0, counter=0

## Timing
- **Grant:** grant at cycle T (IDLE, valid present). `tx_data_valid` is high at T+1. `uart_tx` asserts `Busy` at T+2 or later.
- **Frame end:** first cycle with `tx_busy`=0 in WAIT_DONE, at cycle D, moves the FSM to IDLE at D+1. The earliest next grant is at D+1.
- **Request-to-launch latency:** 1 cycle from grant to `tx_data_valid`.
- **Fairness:** with all requesters continuously valid, grants go 0,1,2,3,0,… One requester never gets two consecutive grants while another is valid.
- **Timeout:** with `Busy` stuck low, `timeout_err` rises BUSY_TIMEOUT+1 cycles after the ISSUE cycle. The FSM re-enters IDLE on the same edge.

## Configuration
- `UART_ARB_STATS_EN`
  - Defined: adds output `frames_sent [15:0]`.
  - It increments on each WAIT_DONE→IDLE transition and wraps at 16'hFFFF→0. Reset value is 0.
  - Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- **Single request:** reset, then `req_valid`=4'b0100 with `req_data[23:16]`=8'hA5 → `req_ready`=4'b0100 for 1 cycle, then `tx_data_valid` pulse with `tx_p_data`=8'hA5 and `grant_id`=2. No further grant until `tx_busy` falls.
- **Round-robin fairness:** all four valid continuously, with a `Busy` model (high 2..11 cycles after launch) → grant order 0,1,2,3,0,1. Exactly one `tx_data_valid` per `Busy` period.
- **Busy already high:** `tx_busy`=1 while in IDLE and `req_valid`=4'b0001 → no `req_ready` until `tx_busy` drops. Grant occurs the cycle after it drops.
- **Timeout:** `BUSY_TIMEOUT`=15, `Busy` held 0 → `timeout_err`=1 exactly 16 cycles after the ISSUE cycle, FSM back in IDLE. The next request is still served.
- **Reset mid-frame:** assert `rst_n`=0 during WAIT_DONE → all outputs reach reset values asynchronously. After release, the first grant goes to requester 0 when all are valid.
- **Statistics (`UART_ARB_STATS_EN` defined):** 3 frames → `frames_sent`=3. Preload near wrap and send 2 frames from 16'hFFFF → 16'h0001.
